// File: rtl/decode_pkg.sv
// Shared types and field indices for the TessiaX32 decode stage.
package decode_pkg;

  typedef enum logic [1:0] {
    IMM8  = 2'b00,
    IMM12 = 2'b01,
    BR24  = 2'b10,
    RSVD  = 2'b11
  } imm_src_t;

  // Bit positions within reg_src_d.
  localparam int unsigned REGSRC_PC = 0;
  localparam int unsigned REGSRC_RD = 1;

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register pending-write counters with busy/full lookups for hazard detection.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int unsigned NREGS = 16,
  parameter int unsigned CNT_W = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic [AW-1:0] inc_addr,
  input  logic          dec_w,
  input  logic [AW-1:0] dec_w_addr,
  input  logic          dec_f,
  input  logic [AW-1:0] dec_f_addr,
  input  logic [AW-1:0] look_a,
  input  logic [AW-1:0] look_b,
  input  logic [AW-1:0] look_dest,
  output logic          busy_a,
  output logic          busy_b,
  output logic          full
);

  localparam int MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] pend_q [NREGS];
  logic [CNT_W-1:0] pend_d [NREGS];

  // A register whose last outstanding write is retiring this cycle is already readable
  // through the regfile bypass, so it is not reported busy.
  assign busy_a = (pend_q[look_a] != '0) &&
                  !(dec_w && (dec_w_addr == look_a) && (pend_q[look_a] == CNT_W'(1)));
  assign busy_b = (pend_q[look_b] != '0) &&
                  !(dec_w && (dec_w_addr == look_b) && (pend_q[look_b] == CNT_W'(1)));
  assign full   = (pend_q[look_dest] == '1);

  always_comb begin
    int n;
    n = 0;
    for (int r = 0; r < NREGS; r++) begin
      n = int'(pend_q[r]);
      if (inc && (inc_addr == AW'(r))) n = n + 1;
      if (dec_w && (dec_w_addr == AW'(r)) && (pend_q[r] != '0)) n = n - 1;
      if (dec_f && (dec_f_addr == AW'(r))) n = n - 1;
      // Saturate rather than wrap in either direction.
      if (n < 0) n = 0;
      if (n > MAX) n = MAX;
      pend_d[r] = CNT_W'(n);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
    end
  end

endmodule

// File: rtl/decode_stage_sb.sv
// Decode stage: regfile with write-through bypass, immediate extension, scoreboard
// hazard detection and the registered D->E pipeline stage.
module decode_stage_sb
  import decode_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned PC_IDX = 15,
  parameter int unsigned CNT_W  = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_d,
  input  logic [31:0]      instr_d,
  input  logic [WIDTH-1:0] pc_plus8_d,
  input  logic [1:0]       reg_src_d,
  input  logic [1:0]       imm_src_d,
  input  logic             reg_write_d,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             reg_write_w,
  input  logic [AW-1:0]    wa3_w,
  input  logic [WIDTH-1:0] result_w,
  output logic             hazard_d,
  output logic             valid_e,
  output logic [WIDTH-1:0] rd1_e,
  output logic [WIDTH-1:0] rd2_e,
  output logic [WIDTH-1:0] ext_imm_e,
  output logic [AW-1:0]    ra1_e,
  output logic [AW-1:0]    ra2_e,
  output logic [AW-1:0]    wa3_e,
  output logic             reg_write_e
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [WIDTH-1:0] rf_q [NREGS];
  logic [AW-1:0]    ra1, ra2, wa3;
  logic [WIDTH-1:0] rd1, rd2, ext_imm;
  logic             sb_busy_a, sb_busy_b, sb_full;
  logic             fire;
  logic             unused_instr;

  // Register fields sit at fixed instruction offsets; the top byte is opcode space.
  assign ra1 = reg_src_d[REGSRC_PC] ? PC_A : instr_d[16 +: AW];
  assign ra2 = reg_src_d[REGSRC_RD] ? instr_d[12 +: AW] : instr_d[0 +: AW];
  assign wa3 = instr_d[12 +: AW];
  assign unused_instr = ^instr_d[31:24];

  assign rd1 = (ra1 == PC_A)                      ? pc_plus8_d :
               (reg_write_w && (wa3_w == ra1))    ? result_w   : rf_q[ra1];
  assign rd2 = (ra2 == PC_A)                      ? pc_plus8_d :
               (reg_write_w && (wa3_w == ra2))    ? result_w   : rf_q[ra2];

  always_comb begin
    ext_imm = '0;
    unique case (imm_src_t'(imm_src_d))
      IMM8:  ext_imm = {{(WIDTH-8){1'b0}}, instr_d[7:0]};
      IMM12: ext_imm = {{(WIDTH-12){1'b0}}, instr_d[11:0]};
      BR24:  ext_imm = {{(WIDTH-26){instr_d[23]}}, instr_d[23:0], 2'b00};
      RSVD:  ext_imm = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
    end else if (reg_write_w && (wa3_w != PC_A)) begin
      rf_q[wa3_w] <= result_w;
    end
  end

  decode_scoreboard #(
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .inc        (fire && reg_write_d && (wa3 != PC_A)),
    .inc_addr   (wa3),
    .dec_w      (reg_write_w),
    .dec_w_addr (wa3_w),
    .dec_f      (flush_e && valid_e && reg_write_e),
    .dec_f_addr (wa3_e),
    .look_a     (ra1),
    .look_b     (ra2),
    .look_dest  (wa3),
    .busy_a     (sb_busy_a),
    .busy_b     (sb_busy_b),
    .full       (sb_full)
  );

  // RA2 is checked even for immediate forms: conservative, never misses a hazard.
  assign hazard_d = valid_d && ((sb_busy_a && (ra1 != PC_A)) ||
                                (sb_busy_b && (ra2 != PC_A)) ||
                                (reg_write_d && sb_full));
  assign fire     = valid_d && !hazard_d && !stall_e && !flush_e;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_e     <= 1'b0;
      reg_write_e <= 1'b0;
      rd1_e       <= '0;
      rd2_e       <= '0;
      ext_imm_e   <= '0;
      ra1_e       <= '0;
      ra2_e       <= '0;
      wa3_e       <= '0;
    end else if (flush_e) begin
      valid_e     <= 1'b0;
      reg_write_e <= 1'b0;
    end else if (stall_e) begin
      valid_e     <= valid_e;
    end else if (fire) begin
      valid_e     <= 1'b1;
      reg_write_e <= reg_write_d;
      rd1_e       <= rd1;
      rd2_e       <= rd2;
      ext_imm_e   <= ext_imm;
      ra1_e       <= ra1;
      ra2_e       <= ra2;
      wa3_e       <= wa3;
    end else begin
      valid_e     <= 1'b0;
      reg_write_e <= 1'b0;
    end
  end

endmodule
